// File: rtl/sc_statemachine_muxarb_if.sv
// Command/status bundle between a controller host and the mux arbiter.
interface sc_statemachine_muxarb_if #(
    parameter int unsigned SEL_WIDTH = 2
);
    logic [SEL_WIDTH-1:0] SC_STATEMACHINE_MUXARB_MODE_InBus;
    logic                 SC_STATEMACHINE_MUXARB_NEWSIGNAL_InLow;
    logic                 SC_STATEMACHINE_MUXARB_STOP_InLow;
    logic                 SC_STATEMACHINE_MUXARB_FLAGGOAL_InLow;
    logic [SEL_WIDTH-1:0] SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus;
    logic                 SC_STATEMACHINE_MUXARB_BUSY_Out;
    logic                 SC_STATEMACHINE_MUXARB_DONE_Out;
    logic                 SC_STATEMACHINE_MUXARB_TIMEOUT_Out;
    logic                 SC_STATEMACHINE_MUXARB_ERROR_Out;

    modport master (
        output SC_STATEMACHINE_MUXARB_MODE_InBus,
        output SC_STATEMACHINE_MUXARB_NEWSIGNAL_InLow,
        output SC_STATEMACHINE_MUXARB_STOP_InLow,
        output SC_STATEMACHINE_MUXARB_FLAGGOAL_InLow,
        input  SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus,
        input  SC_STATEMACHINE_MUXARB_BUSY_Out,
        input  SC_STATEMACHINE_MUXARB_DONE_Out,
        input  SC_STATEMACHINE_MUXARB_TIMEOUT_Out,
        input  SC_STATEMACHINE_MUXARB_ERROR_Out
    );

    modport slave (
        input  SC_STATEMACHINE_MUXARB_MODE_InBus,
        input  SC_STATEMACHINE_MUXARB_NEWSIGNAL_InLow,
        input  SC_STATEMACHINE_MUXARB_STOP_InLow,
        input  SC_STATEMACHINE_MUXARB_FLAGGOAL_InLow,
        output SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus,
        output SC_STATEMACHINE_MUXARB_BUSY_Out,
        output SC_STATEMACHINE_MUXARB_DONE_Out,
        output SC_STATEMACHINE_MUXARB_TIMEOUT_Out,
        output SC_STATEMACHINE_MUXARB_ERROR_Out
    );
endinterface

// File: rtl/sc_statemachine_muxarb.sv
// Mode-select arbiter: latches a controller index, runs it until stop/goal/timeout,
// and reports the stop cause. Outputs are registered and track the state register.
module sc_statemachine_muxarb #(
    parameter int unsigned NUM_MODES      = 2,
    parameter int unsigned SEL_WIDTH      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                     SC_STATEMACHINE_MUXARB_CLOCK_50,
    input  logic                     SC_STATEMACHINE_MUXARB_RESET_InHigh,
    sc_statemachine_muxarb_if.slave  bus
);

    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [SEL_WIDTH-1:0] MODE_LIMIT = SEL_WIDTH'(NUM_MODES);
    localparam logic [SEL_WIDTH-1:0] SEL_STOP   = SEL_WIDTH'(NUM_MODES + 1);
    localparam logic                 TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0]     CNT_LAST   =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

    logic [1:0]           state_q, state_d;
    logic [SEL_WIDTH-1:0] mode_q, mode_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ns_prev_q;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 error_q, error_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 busy_q, busy_d;

    logic                 ns_edge;
    logic                 timeout_hit;

    // Falling edge of the new-command line and the last-RUN-cycle condition.
    always_comb begin
        ns_edge     = ns_prev_q & ~bus.SC_STATEMACHINE_MUXARB_NEWSIGNAL_InLow;
        timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);
    end

    // Next-state, counter, flag and output decode.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        error_d   = error_q;
        sel_d     = '0;
        busy_d    = 1'b0;

        case (state_q)
            ST_RESET: state_d = ST_START;
            ST_START: begin
                mode_d = bus.SC_STATEMACHINE_MUXARB_MODE_InBus;
                if (bus.SC_STATEMACHINE_MUXARB_MODE_InBus < MODE_LIMIT) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_STOP;
                    error_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!bus.SC_STATEMACHINE_MUXARB_STOP_InLow ||
                    !bus.SC_STATEMACHINE_MUXARB_FLAGGOAL_InLow) begin
                    state_d = ST_STOP;
                    done_d  = ~bus.SC_STATEMACHINE_MUXARB_FLAGGOAL_InLow;
                end else if (timeout_hit) begin
                    state_d   = ST_STOP;
                    timeout_d = 1'b1;
                end else if (ns_edge) begin
                    state_d = ST_START;
                end
            end
            ST_STOP: begin
                if (ns_edge) begin
                    state_d   = ST_START;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    error_d   = 1'b0;
                end
            end
            default: state_d = ST_RESET;
        endcase

        case (state_d)
            ST_RUN: begin
                sel_d  = mode_d + SEL_WIDTH'(1);
                busy_d = 1'b1;
            end
            ST_STOP: sel_d = SEL_STOP;
            default: sel_d = '0;
        endcase
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge SC_STATEMACHINE_MUXARB_CLOCK_50) begin
        if (SC_STATEMACHINE_MUXARB_RESET_InHigh) begin
            state_q   <= ST_RESET;
            mode_q    <= '0;
            cnt_q     <= '0;
            ns_prev_q <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            ns_prev_q <= bus.SC_STATEMACHINE_MUXARB_NEWSIGNAL_InLow;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            error_q   <= error_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus = sel_q;
    assign bus.SC_STATEMACHINE_MUXARB_BUSY_Out         = busy_q;
    assign bus.SC_STATEMACHINE_MUXARB_DONE_Out         = done_q;
    assign bus.SC_STATEMACHINE_MUXARB_TIMEOUT_Out      = timeout_q;
    assign bus.SC_STATEMACHINE_MUXARB_ERROR_Out        = error_q;

endmodule

// File: tb/tb_sc_statemachine_muxarb.sv
// Bench for the mux arbiter: two instances (no timeout / timeout of 10) share stimulus
// and are compared every cycle against a behavioural model of the arbiter rules.
module tb_sc_statemachine_muxarb;

    logic clk;
    logic rst;
    logic [1:0] mode;
    logic ns;
    logic stop_n;
    logic goal_n;

    int total;
    int bad;

    sc_statemachine_muxarb_if #(.SEL_WIDTH(2)) if_a ();
    sc_statemachine_muxarb_if #(.SEL_WIDTH(2)) if_b ();

    assign if_a.SC_STATEMACHINE_MUXARB_MODE_InBus      = mode;
    assign if_a.SC_STATEMACHINE_MUXARB_NEWSIGNAL_InLow = ns;
    assign if_a.SC_STATEMACHINE_MUXARB_STOP_InLow      = stop_n;
    assign if_a.SC_STATEMACHINE_MUXARB_FLAGGOAL_InLow  = goal_n;
    assign if_b.SC_STATEMACHINE_MUXARB_MODE_InBus      = mode;
    assign if_b.SC_STATEMACHINE_MUXARB_NEWSIGNAL_InLow = ns;
    assign if_b.SC_STATEMACHINE_MUXARB_STOP_InLow      = stop_n;
    assign if_b.SC_STATEMACHINE_MUXARB_FLAGGOAL_InLow  = goal_n;

    sc_statemachine_muxarb #(.NUM_MODES(2), .SEL_WIDTH(2), .TIMEOUT_CYCLES(0)) dut_a (
        .SC_STATEMACHINE_MUXARB_CLOCK_50     (clk),
        .SC_STATEMACHINE_MUXARB_RESET_InHigh (rst),
        .bus                                 (if_a.slave)
    );

    sc_statemachine_muxarb #(.NUM_MODES(2), .SEL_WIDTH(2), .TIMEOUT_CYCLES(10)) dut_b (
        .SC_STATEMACHINE_MUXARB_CLOCK_50     (clk),
        .SC_STATEMACHINE_MUXARB_RESET_InHigh (rst),
        .bus                                 (if_b.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural model: phase name, latched mode, RUN cycles completed, flags.
    typedef enum int {P_RESET = 100, P_START = 200, P_RUN = 300, P_STOP = 400} phase_t;
    phase_t m_phase [2];
    int     m_mode  [2];
    int     m_runs  [2];
    bit     m_prev  [2];
    bit     m_done  [2];
    bit     m_to    [2];
    bit     m_err   [2];
    int     m_limit [2];

    task automatic model_update();
        bit edge_seen;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] = P_RESET;
                m_mode[k]  = 0;
                m_runs[k]  = 0;
                m_prev[k]  = 1'b1;
                m_done[k]  = 1'b0;
                m_to[k]    = 1'b0;
                m_err[k]   = 1'b0;
            end else begin
                edge_seen = m_prev[k] && !ns;
                m_prev[k] = ns;
                case (m_phase[k])
                    P_RESET: m_phase[k] = P_START;
                    P_START: begin
                        m_mode[k] = int'(mode);
                        if (int'(mode) < 2) begin
                            m_phase[k] = P_RUN;
                            m_runs[k]  = 0;
                        end else begin
                            m_phase[k] = P_STOP;
                            m_err[k]   = 1'b1;
                        end
                    end
                    P_RUN: begin
                        m_runs[k] = m_runs[k] + 1;
                        if (!stop_n || !goal_n) begin
                            m_phase[k] = P_STOP;
                            m_done[k]  = !goal_n;
                        end else if (m_limit[k] != 0 && m_runs[k] == m_limit[k]) begin
                            m_phase[k] = P_STOP;
                            m_to[k]    = 1'b1;
                        end else if (edge_seen) begin
                            m_phase[k] = P_START;
                        end
                    end
                    default: begin
                        if (edge_seen) begin
                            m_phase[k] = P_START;
                            m_done[k]  = 1'b0;
                            m_to[k]    = 1'b0;
                            m_err[k]   = 1'b0;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_sel(input int k);
        case (m_phase[k])
            P_RUN:   return 32'(m_mode[k] + 1);
            P_STOP:  return 32'd3;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_all();
        chk("a_sel",  32'(if_a.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), exp_sel(0));
        chk("a_busy", 32'(if_a.SC_STATEMACHINE_MUXARB_BUSY_Out),    32'(m_phase[0] == P_RUN));
        chk("a_done", 32'(if_a.SC_STATEMACHINE_MUXARB_DONE_Out),    32'(m_done[0]));
        chk("a_to",   32'(if_a.SC_STATEMACHINE_MUXARB_TIMEOUT_Out), 32'(m_to[0]));
        chk("a_err",  32'(if_a.SC_STATEMACHINE_MUXARB_ERROR_Out),   32'(m_err[0]));
        chk("b_sel",  32'(if_b.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), exp_sel(1));
        chk("b_busy", 32'(if_b.SC_STATEMACHINE_MUXARB_BUSY_Out),    32'(m_phase[1] == P_RUN));
        chk("b_done", 32'(if_b.SC_STATEMACHINE_MUXARB_DONE_Out),    32'(m_done[1]));
        chk("b_to",   32'(if_b.SC_STATEMACHINE_MUXARB_TIMEOUT_Out), 32'(m_to[1]));
        chk("b_err",  32'(if_b.SC_STATEMACHINE_MUXARB_ERROR_Out),   32'(m_err[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        int a_idle;
        total = 0;
        bad   = 0;
        m_limit[0] = 0;
        m_limit[1] = 10;
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = P_RESET;
            m_mode[k]  = 0;
            m_runs[k]  = 0;
            m_prev[k]  = 1'b1;
            m_done[k]  = 1'b0;
            m_to[k]    = 1'b0;
            m_err[k]   = 1'b0;
        end
        rst = 1'b1; mode = 2'd1; ns = 1'b1; stop_n = 1'b1; goal_n = 1'b1;

        // Reset, START, then RUN with mode 1
        step();
        chk("rst_sel", 32'(if_a.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), 32'd0);
        rst = 1'b0;
        step();
        chk("start_sel", 32'(if_a.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), 32'd0);
        step();
        chk("run_sel", 32'(if_a.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), 32'd2);
        chk("run_busy", 32'(if_a.SC_STATEMACHINE_MUXARB_BUSY_Out), 32'd1);

        // Goal for one cycle, flag held in STOP, cleared by a NEWSIGNAL edge
        goal_n = 1'b0;
        step();
        goal_n = 1'b1;
        chk("goal_sel", 32'(if_a.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), 32'd3);
        chk("goal_done", 32'(if_a.SC_STATEMACHINE_MUXARB_DONE_Out), 32'd1);
        for (int i = 0; i < 3; i++) step();
        chk("goal_hold", 32'(if_a.SC_STATEMACHINE_MUXARB_DONE_Out), 32'd1);
        ns = 1'b0;
        step();
        chk("restart_sel", 32'(if_a.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), 32'd0);
        chk("restart_done", 32'(if_a.SC_STATEMACHINE_MUXARB_DONE_Out), 32'd0);

        // Timeout of 10 RUN cycles on instance b, mode 0
        ns = 1'b1; mode = 2'd0;
        step();
        for (int i = 0; i < 9; i++) step();
        chk("to_still_run", 32'(if_b.SC_STATEMACHINE_MUXARB_BUSY_Out), 32'd1);
        step();
        chk("to_sel", 32'(if_b.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), 32'd3);
        chk("to_flag", 32'(if_b.SC_STATEMACHINE_MUXARB_TIMEOUT_Out), 32'd1);
        chk("no_to_a", 32'(if_a.SC_STATEMACHINE_MUXARB_BUSY_Out), 32'd1);

        // NEWSIGNAL held low: a single re-latch on instance a
        ns = 1'b0;
        step();
        ns = 1'b1;
        step();
        ns = 1'b0;
        a_idle = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (if_a.SC_STATEMACHINE_MUXARB_BUSY_Out !== 1'b1) a_idle++;
        end
        chk("held_low_relatch", 32'(a_idle), 32'd1);

        // STOP and NEWSIGNAL edge together: STOP wins, no flag
        ns = 1'b1;
        step();
        ns = 1'b0; stop_n = 1'b0;
        step();
        stop_n = 1'b1;
        chk("stopwin_sel", 32'(if_a.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), 32'd3);
        chk("stopwin_done", 32'(if_a.SC_STATEMACHINE_MUXARB_DONE_Out), 32'd0);

        // Goal on the 10th RUN cycle: DONE beats TIMEOUT on instance b
        rst = 1'b1; ns = 1'b1;
        step();
        rst = 1'b0; mode = 2'd0;
        step();
        step();
        for (int i = 0; i < 9; i++) step();
        goal_n = 1'b0;
        step();
        goal_n = 1'b1;
        chk("goal10_done", 32'(if_b.SC_STATEMACHINE_MUXARB_DONE_Out), 32'd1);
        chk("goal10_to", 32'(if_b.SC_STATEMACHINE_MUXARB_TIMEOUT_Out), 32'd0);

        // Out-of-range mode gives ERROR
        ns = 1'b0;
        step();
        ns = 1'b1; mode = 2'd3;
        step();
        chk("err_flag", 32'(if_a.SC_STATEMACHINE_MUXARB_ERROR_Out), 32'd1);
        chk("err_sel", 32'(if_a.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), 32'd3);

        // Reset mid-RUN
        ns = 1'b0;
        step();
        ns = 1'b1; mode = 2'd1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_sel", 32'(if_a.SC_STATEMACHINE_MUXARB_MUXSELECT_OutBus), 32'd0);
        chk("midrst_busy", 32'(if_a.SC_STATEMACHINE_MUXARB_BUSY_Out), 32'd0);
        chk("midrst_flags", 32'({if_a.SC_STATEMACHINE_MUXARB_DONE_Out,
                                 if_a.SC_STATEMACHINE_MUXARB_TIMEOUT_Out,
                                 if_a.SC_STATEMACHINE_MUXARB_ERROR_Out}), 32'd0);

        // Randomized soak against the model
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            mode   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ns = ~ns;
            stop_n = ($urandom_range(0, 19) != 0);
            goal_n = ($urandom_range(0, 15) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
